fp_accum_driver: RTL and testbench
==================================

// Module: fp_accum_driver
// PURPOSE
//  Initiator side of the load / result_ready / result_ack handshake used by the fp32 adder.
//  Accepts a stream of IEEE-754 single-precision terms and issues one add per term after the first.
//  Keeps a running sum in an internal accumulator. Presents the final sum and term count when a
//  term flagged last has been folded in. Sits between an operand source and one adder instance.
// PARAMETERS
//  CNT_W    16  width of term counter; saturates at 2^CNT_W-1
//  TIMEOUT  64  cycles in WAIT_RES without add_ready before timeout_err is raised
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset
//  in_valid     in   1       term available on in_data
//  in_ready     out  1       driver can accept a term
//  in_data      in   32      fp32 term
//  in_last      in   1       this term ends the sequence
//  add_load     out  1       one-cycle load request to adder
//  add_a        out  32      adder operand 1 (accumulator)
//  add_b        out  32      adder operand 2 (new term)
//  add_result   in   32      adder result, valid while add_ready=1
//  add_ready    in   1       adder result valid
//  add_ack      out  1       one-cycle result acknowledge to adder
//  sum_valid    out  1       final sum available
//  sum_data     out  32      final sum
//  sum_count    out  CNT_W   number of terms in sum
//  sum_ack      in   1       consumer takes sum
//  timeout_err  out  1       sticky: adder never answered
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; acc, count, last_q, timer = 0; all outputs 0.
//  All outputs are registered.
//  States: IDLE, ACCUM, ISSUE, WAIT_RES, ACK, DONE, ERR.
//  - IDLE: in_ready=1. On in_valid&in_ready: acc<=in_data, count<=1.
//    Go to DONE if in_last, else ACCUM. The first term never goes through the adder.
//  - ACCUM: in_ready=1. On handshake: add_a<=acc, add_b<=in_data, last_q<=in_last,
//    count<=count+1 (saturating). Go to ISSUE.
//  - ISSUE: add_load=1 for exactly this one cycle. Go to WAIT_RES. Clear timer.
//  - WAIT_RES: add_load=0. add_a/add_b held stable from ISSUE until leaving ACK. timer++.
//    If add_ready=1: acc<=add_result, go to ACK.
//    Else if timer==TIMEOUT-1: timeout_err<=1, go to ERR.
//    add_ready is sampled only in WAIT_RES. The stale add_ready high during ACK and the cycle
//    after is ignored.
//  - ACK: add_ack=1 for exactly one cycle. Go to DONE if last_q, else ACCUM.
//  - DONE: in_ready=0, sum_valid=1. sum_data=acc and sum_count=count, both stable until sum_ack.
//    On sum_ack: go to IDLE. sum_valid=0 and count=0 on the next cycle.
//  - ERR: in_ready=0, all handshake outputs 0, timeout_err=1. Left only by reset.
//  in_ready=0 in ISSUE, WAIT_RES, ACK, DONE and ERR. Driver issues no load while a result is
//    outstanding.
//  Driver does no FP arithmetic or inspection. Zero, denormal and negative terms all go to the
//    adder unchanged.
//  in_last on the IDLE term gives count=1 and no adder traffic.
//  Simultaneous sum_ack and in_valid in DONE: term not accepted, because in_ready=0 there.
//    It is accepted in IDLE.
//  Throughput with the companion adder: 1 handshake + 1 ISSUE + adder latency (result_ready 3
//    cycles after the load edge) + 1 ACK, i.e. about 6 cycles per added term.
// TESTING
//  1. Single term 0x3F800000, in_last=1 -> sum_valid next cycle, sum_data=0x3F800000,
//     sum_count=1, add_load never high.
//  2. Terms 0x3F800000, 0x40000000, 0x40400000 (last), ideal-adder model -> exactly 2 add_load
//     pulses. First add_a/add_b=0x3F800000/0x40000000. sum_data=0x40C00000, sum_count=3.
//  3. Adder model delays add_ready by 10 cycles -> add_load high 1 cycle only, add_a/add_b stable,
//     in_ready=0 throughout, add_ack exactly 1 cycle after add_ready seen.
//  4. Adder model never answers, TIMEOUT=64 -> timeout_err=1 after 64 WAIT_RES cycles,
//     in_ready=0, stays until reset.
//  5. sum_ack held low 20 cycles in DONE -> sum_valid/sum_data/sum_count stable, in_valid ignored.
//     Then sum_ack=1 -> IDLE, in_ready=1 next cycle.
//  6. reset low mid-WAIT_RES -> all outputs 0 immediately. A new 2-term sequence after release
//     completes correctly.

Source files
------------

// File: rtl/fp_accum_driver.sv
// fp_accum_driver: folds a stream of fp32 terms through an external adder and presents the final sum
module fp_accum_driver #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             add_load,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  input  logic             add_ready,
  output logic             add_ack,
  output logic             sum_valid,
  output logic [31:0]      sum_data,
  output logic [CNT_W-1:0] sum_count,
  input  logic             sum_ack,
  output logic             timeout_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ACCUM, ISSUE, WAIT_RES, ACK, DONE, ERR} state_t;
  state_t state, state_n;
  logic [31:0] acc, acc_n, a_n, b_n;
  logic [CNT_W-1:0] count, count_n, count_inc;
  logic last_q, last_n;
  logic [TW-1:0] timer, timer_n;
  logic take;
  assign take = in_valid & in_ready;
  assign count_inc = &count ? count : count + 1'b1;
  // next state and next datapath values; the first term loads acc directly, later terms go to the adder
  always_comb begin
    state_n = state;
    acc_n   = acc;
    count_n = count;
    last_n  = last_q;
    timer_n = timer;
    a_n     = add_a;
    b_n     = add_b;
    case (state)
      IDLE: if (take) begin
        acc_n   = in_data;
        count_n = CNT_W'(1);
        state_n = in_last ? DONE : ACCUM;
      end
      ACCUM: if (take) begin
        a_n     = acc;
        b_n     = in_data;
        last_n  = in_last;
        count_n = count_inc;
        state_n = ISSUE;
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT_RES;
      end
      WAIT_RES: begin
        timer_n = timer + 1'b1;
        if (add_ready) begin
          acc_n   = add_result;
          state_n = ACK;
        end else if (timer == TMAX) state_n = ERR;
      end
      ACK: state_n = last_q ? DONE : ACCUM;
      DONE: if (sum_ack) begin
        count_n = '0;
        state_n = IDLE;
      end
      default: state_n = ERR;
    endcase
  end
  // state, datapath and outputs all registered; outputs decode the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      last_q      <= 1'b0;
      timer       <= '0;
      in_ready    <= 1'b0;
      add_load    <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      add_ack     <= 1'b0;
      sum_valid   <= 1'b0;
      sum_data    <= '0;
      sum_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      count       <= count_n;
      last_q      <= last_n;
      timer       <= timer_n;
      in_ready    <= state_n == IDLE || state_n == ACCUM;
      add_load    <= state_n == ISSUE;
      add_a       <= a_n;
      add_b       <= b_n;
      add_ack     <= state_n == ACK;
      sum_valid   <= state_n == DONE;
      sum_data    <= state_n == DONE ? acc_n : '0;
      sum_count   <= state_n == DONE ? count_n : '0;
      timeout_err <= state_n == ERR;
    end
  end
endmodule

// File: tb/tb_fp_accum_driver.sv
// tb_fp_accum_driver: randomized self-checking bench with an integer-valued fp32 adder model
module tb_fp_accum_driver;
  logic clk = 0, reset = 0;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [31:0] in_data = 0;
  logic add_load, add_ready, add_ack, sum_valid, sum_ack = 0, timeout_err;
  logic [31:0] add_a, add_b, add_result, sum_data;
  logic [15:0] sum_count;
  int checks = 0, passes = 0;
  int lat = 3, pend = 0, stale = 0, ack_err = 0, load_err = 0, stab_err = 0, busy_err = 0;
  bit never = 0, ackwait = 0, outst = 0, prev_load = 0, prev_ack = 0;
  logic [31:0] model_r, cap_a, cap_b;
  logic [31:0] ld_a[$], ld_b[$];
  int seq[$];

  fp_accum_driver #(.CNT_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .add_load(add_load), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_ready(add_ready), .add_ack(add_ack), .sum_valid(sum_valid),
    .sum_data(sum_data), .sum_count(sum_count), .sum_ack(sum_ack), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] i2f(input int n);
    int p = 31;
    if (n == 0) return 32'h0;
    while (!n[p]) p--;
    return {1'b0, 8'(127 + p), 23'(n << (23 - p))};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    if (f[30:0] == 0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    return int'({1'b1, f[22:0]}) >> (23 - e);
  endfunction

  // adder model: result lat cycles after the load, held one extra cycle past the ack
  initial begin
    add_ready = 0;
    add_result = 0;
    forever begin
      @(posedge clk); #1;
      if (stale > 0) begin
        stale--;
        if (stale == 0) add_ready = 0;
      end
      if (!reset) begin
        pend = 0; ackwait = 0; stale = 0; add_ready = 0;
      end else if (pend > 0) begin
        pend--;
        if (add_ack) ack_err++;
        if (pend == 0) begin
          add_ready = 1; add_result = model_r; ackwait = 1;
        end
      end else if (ackwait) begin
        ackwait = 0;
        if (!add_ack) ack_err++;
        stale = 2;
      end
      if (reset && add_load && !never) begin
        model_r = i2f(f2i(add_a) + f2i(add_b));
        pend = lat;
      end
    end
  end

  // protocol monitor: load width, operand stability, in_ready while busy, ack width
  initial forever begin
    @(posedge clk); #1;
    if (!reset) begin
      outst = 0; prev_load = 0; prev_ack = 0;
    end else begin
      if (add_load && prev_load) load_err++;
      if (add_ack && prev_ack) ack_err++;
      if (add_load) begin
        ld_a.push_back(add_a); ld_b.push_back(add_b);
        cap_a = add_a; cap_b = add_b; outst = 1;
      end else if (outst) begin
        if (add_a !== cap_a || add_b !== cap_b) stab_err++;
        if (add_ack) outst = 0;
      end
      if ((outst || add_ack) && in_ready) busy_err++;
      prev_load = add_load;
      prev_ack = add_ack;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 3ms");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    logic ok = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!ok && n < 500) begin
      ok = in_ready;
      cyc(1);
      n++;
    end
    in_valid = 0; in_last = 0;
    checks++;
    if (!ok) $display("FAIL send_handshake: in_ready never high for term %h, required 1", d);
    else passes++;
  endtask

  task automatic wait_sum(input string name);
    int n = 0;
    while (!sum_valid && n < 2000) begin cyc(1); n++; end
    checks++;
    if (sum_valid !== 1'b1) $display("FAIL %s_sum_valid: got %b required 1", name, sum_valid);
    else passes++;
  endtask

  task automatic take_sum(input string name);
    sum_ack = 1;
    cyc(1);
    sum_ack = 0;
    checks++;
    if ({sum_valid, in_ready} !== 2'b01)
      $display("FAIL %s_release: sum_valid,in_ready got %b required 01", name, {sum_valid, in_ready});
    else passes++;
  endtask

  task automatic do_reset();
    reset = 0; in_valid = 0; sum_ack = 0; never = 0; lat = 3;
    cyc(2);
    reset = 1;
    cyc(1);
  endtask

  task automatic run_seq(input string name);
    int tot = 0, pre = 0, n;
    n = seq.size();
    ld_a.delete(); ld_b.delete();
    foreach (seq[i]) tot += seq[i];
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 4));
      send(i2f(seq[i]), i == n - 1);
    end
    wait_sum(name);
    checks++;
    if (sum_data !== i2f(tot)) $display("FAIL %s_sum_data: got %h required %h", name, sum_data, i2f(tot));
    else passes++;
    checks++;
    if (sum_count !== 16'(n)) $display("FAIL %s_sum_count: got %0d required %0d", name, sum_count, n);
    else passes++;
    checks++;
    if (ld_a.size() != n - 1) $display("FAIL %s_load_count: got %0d required %0d", name, ld_a.size(), n - 1);
    else passes++;
    for (int i = 0; i < n - 1 && i < ld_a.size(); i++) begin
      pre += seq[i];
      checks++;
      if ({ld_a[i], ld_b[i]} !== {i2f(pre), i2f(seq[i + 1])})
        $display("FAIL %s_operands[%0d]: got %h/%h required %h/%h", name, i, ld_a[i], ld_b[i], i2f(pre), i2f(seq[i + 1]));
      else passes++;
    end
    cyc($urandom_range(0, 5));
    take_sum(name);
  endtask

  task automatic test_reset();
    reset = 0;
    cyc(2);
    checks++;
    if ({in_ready, add_load, add_ack, sum_valid, timeout_err, add_a, add_b, sum_data, sum_count} !== '0)
      $display("FAIL reset_outputs: some output nonzero in reset, required all 0");
    else passes++;
    reset = 1;
    cyc(1);
    checks++;
    if ({in_ready, sum_valid} !== 2'b10) $display("FAIL reset_idle: in_ready,sum_valid got %b required 10", {in_ready, sum_valid});
    else passes++;
  endtask

  task automatic test_single();
    ld_a.delete();
    send(32'h3F800000, 1);
    checks++;
    if ({sum_valid, sum_data, sum_count} !== {1'b1, 32'h3F800000, 16'd1})
      $display("FAIL single_sum: got %b/%h/%0d required 1/3f800000/1", sum_valid, sum_data, sum_count);
    else passes++;
    checks++;
    if (ld_a.size() != 0) $display("FAIL single_no_load: got %0d loads required 0", ld_a.size());
    else passes++;
    take_sum("single");
  endtask

  task automatic test_three();
    seq = '{1, 2, 3};
    run_seq("three");
    checks++;
    if ({ld_a.size(), ld_a[0], ld_b[0]} !== {32'd2, 32'h3F800000, 32'h40000000})
      $display("FAIL three_first_load: got %0d %h/%h required 2 3f800000/40000000", ld_a.size(), ld_a[0], ld_b[0]);
    else passes++;
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      seq.delete();
      repeat ($urandom_range(1, 6)) seq.push_back(int'($urandom_range(0, 1000)));
      run_seq("random");
    end
  endtask

  task automatic test_slow_adder();
    lat = 10;
    seq = '{5, 7, 11};
    run_seq("slow");
    lat = 64;
    seq = '{2, 9};
    run_seq("lat64");
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL lat64_no_timeout: got %b required 0", timeout_err);
    else passes++;
    lat = 3;
  endtask

  task automatic test_raw_terms();
    ld_a.delete(); ld_b.delete();
    send(32'h80000001, 0);
    send(32'h00000001, 1);
    wait_sum("raw");
    checks++;
    if ({ld_a[0], ld_b[0], sum_count} !== {32'h80000001, 32'h00000001, 16'd2})
      $display("FAIL raw_operands: got %h/%h/%0d required 80000001/00000001/2", ld_a[0], ld_b[0], sum_count);
    else passes++;
    take_sum("raw");
  endtask

  task automatic test_done_hold();
    send(i2f(9), 0);
    send(i2f(4), 1);
    wait_sum("hold");
    in_valid = 1; in_data = i2f(100); in_last = 1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({sum_valid, in_ready, sum_data, sum_count} !== {2'b10, i2f(13), 16'd2})
        $display("FAIL hold_cycle[%0d]: got %b%b/%h/%0d required 10/%h/2", i, sum_valid, in_ready, sum_data, sum_count, i2f(13));
      else passes++;
      cyc(1);
    end
    take_sum("hold");
    cyc(1);
    in_valid = 0; in_last = 0;
    checks++;
    if ({sum_valid, sum_data, sum_count} !== {1'b1, i2f(100), 16'd1})
      $display("FAIL hold_idle_accept: got %b/%h/%0d required 1/%h/1", sum_valid, sum_data, sum_count, i2f(100));
    else passes++;
    take_sum("hold2");
  endtask

  task automatic test_timeout();
    never = 1;
    send(i2f(1), 0);
    send(i2f(2), 1);
    checks++;
    if (add_load !== 1'b1) $display("FAIL timeout_issue: add_load got %b required 1", add_load);
    else passes++;
    cyc(64);
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_early: got %b required 0", timeout_err);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      checks++;
      if ({timeout_err, in_ready, add_load, add_ack, sum_valid} !== 5'b10000)
        $display("FAIL timeout_err_state[%0d]: got %b required 10000", i, {timeout_err, in_ready, add_load, add_ack, sum_valid});
      else passes++;
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    never = 1;
    send(i2f(3), 0);
    send(i2f(4), 1);
    cyc(5);
    reset = 0;
    #1;
    checks++;
    if ({in_ready, add_load, add_ack, sum_valid, timeout_err, add_a, add_b, sum_data, sum_count} !== '0)
      $display("FAIL midwait_reset: outputs nonzero, required all 0 immediately");
    else passes++;
    #1;
    cyc(1);
    reset = 1;
    never = 0;
    cyc(1);
    seq = '{3, 4};
    run_seq("post_reset");
  endtask

  task automatic test_protocol();
    checks++;
    if ({load_err, stab_err, busy_err, ack_err} !== '0)
      $display("FAIL protocol: load/stable/busy/ack errors got %0d/%0d/%0d/%0d required 0/0/0/0", load_err, stab_err, busy_err, ack_err);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_random();
    test_slow_adder();
    test_raw_terms();
    test_done_hold();
    test_timeout();
    test_reset_mid_wait();
    test_protocol();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
